// File: rtl/ps2_key_if.sv
// Stream bundle for the PS/2 key decoder: raw scan-code bytes in, decoded key events out.
interface ps2_key_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic       out_ext;
    logic       out_break;
    logic       out_repeat;

    // Producer of bytes and consumer of events.
    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_code, out_ext, out_break, out_repeat
    );

    // The decoder itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_code, out_ext, out_break, out_repeat
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: byte FIFO, prefix (E0/F0) tracking FSM, registered key-event
// output with valid/ready handshake, and held-key / press-count bookkeeping.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    ps2_key_if.slave   bus,
    output logic       key_down,
    output logic [7:0] held_code,
    output logic [7:0] press_count,
    output logic       overflow
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_code_q, out_code_d;
    logic        out_ext_q, out_ext_d;
    logic        out_break_q, out_break_d;
    logic        out_repeat_q, out_repeat_d;
    logic        key_down_q, key_down_d;
    logic [8:0]  held_id_q, held_id_d;
    logic [7:0]  press_count_q, press_count_d;
    logic        overflow_q, overflow_d;

    logic        full, empty, pop, push;
    logic [7:0]  pop_byte;
    logic        is_ext, is_brk;
    logic [8:0]  key_id;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_C;
    assign empty    = wr_ptr_q == rd_ptr_q;
    assign pop      = !empty && (!out_valid_q || bus.out_ready);
    assign push     = bus.in_valid && (!full || pop);
    assign pop_byte = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state: FIFO pointers, prefix FSM, event register and key bookkeeping.
    always_comb begin
        wr_ptr_d      = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d      = rd_ptr_q + (AW + 1)'(pop);
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_code_d    = out_code_q;
        out_ext_d     = out_ext_q;
        out_break_d   = out_break_q;
        out_repeat_d  = out_repeat_q;
        key_down_d    = key_down_q;
        held_id_d     = held_id_q;
        press_count_d = press_count_q;
        overflow_d    = overflow_q | (bus.in_valid && !push);
        is_ext        = (state_q == EXT) || (state_q == EXT_BRK);
        is_brk        = (state_q == BRK) || (state_q == EXT_BRK);
        key_id        = {is_ext, pop_byte};

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (pop) begin
            case (pop_byte)
                8'hE0: begin
                    if (state_q == IDLE)     state_d = EXT;
                    else if (state_q == BRK) state_d = EXT_BRK;
                end
                8'hF0: begin
                    if (state_q == IDLE)     state_d = BRK;
                    else if (state_q == EXT) state_d = EXT_BRK;
                end
                8'h00, 8'hFF: begin
                    // Keyboard error codes abandon any pending prefix.
                    state_d = IDLE;
                end
                default: begin
                    state_d      = IDLE;
                    out_valid_d  = 1'b1;
                    out_code_d   = pop_byte;
                    out_ext_d    = is_ext;
                    out_break_d  = is_brk;
                    out_repeat_d = 1'b0;
                    if (!is_brk) begin
                        if (key_down_q && (held_id_q == key_id)) begin
                            out_repeat_d = 1'b1;
                        end else begin
                            press_count_d = press_count_q + 8'd1;
                            key_down_d    = 1'b1;
                            held_id_d     = key_id;
                        end
                    end else if (key_down_q && (held_id_q == key_id)) begin
                        key_down_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_code_q    <= 8'h00;
            out_ext_q     <= 1'b0;
            out_break_q   <= 1'b0;
            out_repeat_q  <= 1'b0;
            key_down_q    <= 1'b0;
            held_id_q     <= 9'h000;
            press_count_q <= 8'h00;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_code_q    <= out_code_d;
            out_ext_q     <= out_ext_d;
            out_break_q   <= out_break_d;
            out_repeat_q  <= out_repeat_d;
            key_down_q    <= key_down_d;
            held_id_q     <= held_id_d;
            press_count_q <= press_count_d;
            overflow_q    <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_code   = out_code_q;
    assign bus.out_ext    = out_ext_q;
    assign bus.out_break  = out_break_q;
    assign bus.out_repeat = out_repeat_q;
    assign key_down       = key_down_q;
    assign held_code      = held_id_q[7:0];
    assign press_count    = press_count_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: directed scenarios plus randomized traffic against a
// transaction-level queue model.
module tb_ps2_key_decoder;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic       key_down;
    logic [7:0] held_code;
    logic [7:0] press_count;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_key_if bus();

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus.slave),
        .key_down   (key_down),
        .held_code  (held_code),
        .press_count(press_count),
        .overflow   (overflow)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    logic [7:0]  m_fifo[$];
    bit          m_ext, m_brk;
    bit          m_ov, m_e, m_b, m_r, m_down, m_ovf;
    logic [7:0]  m_code, m_cnt;
    logic [8:0]  m_held;

    logic [10:0] got_ev[$];
    logic [10:0] exp_ev[$];
    logic [7:0]  stim[$];

    function automatic logic [10:0] ev(input logic [7:0] c, input bit e, input bit b, input bit r);
        return {c, e, b, r};
    endfunction

    task automatic model_tick();
        bit         pop, push;
        logic [7:0] b;
        logic [8:0] id;
        if (!resetn) begin
            m_fifo.delete();
            {m_ext, m_brk, m_ov, m_e, m_b, m_r, m_down, m_ovf} = '0;
            m_code = 8'h00; m_cnt = 8'h00; m_held = 9'h000;
            return;
        end
        pop  = (m_fifo.size() > 0) && (!m_ov || bus.out_ready);
        push = bus.in_valid && ((m_fifo.size() < DEPTH) || pop);
        if (bus.in_valid && !push) m_ovf = 1'b1;
        if (m_ov && bus.out_ready) m_ov = 1'b0;
        if (pop) begin
            b = m_fifo.pop_front();
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'h00 || b == 8'hFF) begin
                m_ext = 1'b0; m_brk = 1'b0;
            end else begin
                id = {m_ext, b};
                m_ov = 1'b1; m_code = b; m_e = m_ext; m_b = m_brk; m_r = 1'b0;
                if (!m_brk) begin
                    if (m_down && m_held == id) m_r = 1'b1;
                    else begin
                        m_cnt++; m_down = 1'b1; m_held = id;
                    end
                end else if (m_down && m_held == id) m_down = 1'b0;
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end
        if (push) m_fifo.push_back(bus.in_data);
    endtask

    task automatic compare_all();
        chk("out_valid",   32'(bus.out_valid),  32'(m_ov));
        chk("out_code",    32'(bus.out_code),   32'(m_code));
        chk("out_ext",     32'(bus.out_ext),    32'(m_e));
        chk("out_break",   32'(bus.out_break),  32'(m_b));
        chk("out_repeat",  32'(bus.out_repeat), 32'(m_r));
        chk("key_down",    32'(key_down),       32'(m_down));
        chk("held_code",   32'(held_code),      32'(m_held[7:0]));
        chk("press_count", 32'(press_count),    32'(m_cnt));
        chk("overflow",    32'(overflow),       32'(m_ovf));
    endtask

    task automatic step();
        if (resetn === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            got_ev.push_back(ev(bus.out_code, bus.out_ext, bus.out_break, bus.out_repeat));
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_stim();
        foreach (stim[i]) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim[i];
            step();
        end
        bus.in_valid = 1'b0;
        stim.delete();
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        bus.in_valid = 1'b0;
        idle(2);
        resetn = 1'b1;
        got_ev.delete();
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_count"}, 32'(got_ev.size()), 32'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
            chk($sformatf("%s_ev%0d", tag, i), 32'(got_ev[i]), 32'(exp_ev[i]));
        got_ev.delete();
        exp_ev.delete();
    endtask

    initial begin
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;

        // Reset state and basic make/break with latency check
        do_reset();
        chk("rst_out_valid",   32'(bus.out_valid), 32'd0);
        chk("rst_press_count", 32'(press_count),   32'd0);
        chk("rst_overflow",    32'(overflow),      32'd0);
        bus.in_valid = 1'b1; bus.in_data = 8'h1C; step();
        chk("lat_edge1", 32'(bus.out_valid), 32'd0);
        bus.in_data = 8'hF0; step();
        chk("lat_edge2", 32'(bus.out_valid), 32'd1);
        bus.in_data = 8'h1C; step();
        bus.in_valid = 1'b0;
        idle(4);
        exp_ev.push_back(ev(8'h1C, 0, 0, 0));
        exp_ev.push_back(ev(8'h1C, 0, 1, 0));
        check_events("makebrk");
        chk("makebrk_press", 32'(press_count), 32'd1);
        chk("makebrk_down",  32'(key_down),    32'd0);

        // Extended key make/break
        do_reset();
        stim = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        send_stim();
        idle(6);
        exp_ev.push_back(ev(8'h75, 1, 0, 0));
        exp_ev.push_back(ev(8'h75, 1, 1, 0));
        check_events("ext");
        chk("ext_down", 32'(key_down), 32'd0);

        // Typematic repeat
        do_reset();
        stim = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        send_stim();
        idle(6);
        exp_ev.push_back(ev(8'h1C, 0, 0, 0));
        exp_ev.push_back(ev(8'h1C, 0, 0, 1));
        exp_ev.push_back(ev(8'h1C, 0, 0, 1));
        exp_ev.push_back(ev(8'h1C, 0, 1, 0));
        check_events("rep");
        chk("rep_press", 32'(press_count), 32'd1);

        // Backpressure: output register plus full FIFO hold nine bytes, tenth is dropped
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) stim.push_back(8'h15 + 8'(i));
        send_stim();
        chk("bp_no_ovf_yet", 32'(overflow), 32'd0);
        stim = '{8'h1E};
        send_stim();
        chk("bp_ovf", 32'(overflow), 32'd1);
        idle(3);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_code",  32'(bus.out_code),  32'h15);
        bus.out_ready = 1'b1;
        idle(12);
        for (int i = 0; i < 9; i++) exp_ev.push_back(ev(8'h15 + 8'(i), 0, 0, 0));
        check_events("bp");
        chk("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Error byte cancels pending break prefix
        do_reset();
        stim = '{8'hF0, 8'hFF, 8'h1C};
        send_stim();
        idle(4);
        exp_ev.push_back(ev(8'h1C, 0, 0, 0));
        check_events("err");
        chk("err_press", 32'(press_count), 32'd1);

        // Press counter wraps after 256 distinct makes
        do_reset();
        for (int i = 0; i < 256; i++) stim.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
        send_stim();
        idle(4);
        chk("wrap_events", 32'(got_ev.size()), 32'd256);
        chk("wrap_press",  32'(press_count),   32'd0);
        got_ev.delete();

        // Reset mid-sequence discards prefix state and ignores input
        do_reset();
        stim = '{8'hE0, 8'hF0};
        send_stim();
        idle(2);
        resetn = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h1C;
        idle(2);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_code",  32'(bus.out_code),  32'd0);
        chk("midrst_down",  32'(key_down),      32'd0);
        resetn = 1'b1; bus.in_valid = 1'b0;
        step();
        got_ev.delete();
        stim = '{8'h1C};
        send_stim();
        idle(4);
        exp_ev.push_back(ev(8'h1C, 0, 0, 0));
        check_events("midrst");

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            int sel;
            sel = $urandom_range(0, 9);
            resetn        = ($urandom_range(0, 499) != 0);
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            case (sel)
                0:       bus.in_data = 8'hE0;
                1:       bus.in_data = 8'hF0;
                2:       bus.in_data = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                3, 4:    bus.in_data = 8'h1C;
                5:       bus.in_data = 8'h75;
                6:       bus.in_data = 8'h5A;
                default: bus.in_data = 8'($urandom);
            endcase
            step();
        end
        resetn = 1'b1; bus.in_valid = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
